// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// State encodings and a ceiling-log2 helper for sizing the iteration counter.
package divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_t;

  // Bits needed to hold 0 .. value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift the partial remainder, bring in the next
// dividend bit, trial-subtract the divisor and keep or restore.
module divider_step
  import divider_pkg::*;
#(
  parameter int DATA_WIDTH_2 = 16
) (
  input  logic [DATA_WIDTH_2:0]   part_rem,
  input  logic [DATA_WIDTH_2-1:0] divisor,
  input  logic                    next_bit,
  output logic [DATA_WIDTH_2:0]   next_rem,
  output logic                    quot_bit
);

  logic [DATA_WIDTH_2+1:0] shifted;
  logic [DATA_WIDTH_2+1:0] trial;

  always_comb begin
    shifted  = {part_rem, next_bit};
    trial    = shifted - {2'b00, divisor};
    // A borrow out of the top bit means the divisor did not fit: restore.
    quot_bit = ~trial[DATA_WIDTH_2+1];
    next_rem = quot_bit ? trial[DATA_WIDTH_2:0] : shifted[DATA_WIDTH_2:0];
  end

endmodule

// File: rtl/divider_seq.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Build option DIVIDER_SIGNED_EN: two's-complement operands with a sign-fix cycle.
module divider_seq
  import divider_pkg::*;
#(
  parameter int DATA_WIDTH_1 = 16,
  parameter int DATA_WIDTH_2 = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [DATA_WIDTH_1-1:0] data1_i,
  input  logic [DATA_WIDTH_2-1:0] data2_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [DATA_WIDTH_1-1:0] quot_o,
  output logic [DATA_WIDTH_2-1:0] rem_o,
  output logic                    div_zero_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  // state | meaning
  // IDLE  | ready_o high, waiting for operands
  // BUSY  | one quotient bit per cycle, counter DATA_WIDTH_1-1 down to 0
  // FIX   | signed build only: apply quotient/remainder signs to magnitudes
  // DONE  | result held; valid_o rises one cycle after entry, left on valid_o&ready_i

  localparam int CNT_W = clog2(DATA_WIDTH_1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH_1-1:0] quot_q;
  logic [DATA_WIDTH_2:0]   rem_q;
  logic [DATA_WIDTH_2-1:0] divisor_q;
  logic                    valid_q;
  logic                    div_zero_q;

  logic                    accept;
  logic                    consume;
  logic                    divisor_zero;
  logic [DATA_WIDTH_2:0]   step_rem;
  logic                    step_bit;
  logic [DATA_WIDTH_1-1:0] dividend_ld;
  logic [DATA_WIDTH_2-1:0] divisor_ld;
  logic [DATA_WIDTH_1-1:0] zero_quot;

  assign ready_o      = (state_q == IDLE);
  assign accept       = valid_i & ready_o;
  assign consume      = valid_q & ready_i;
  assign divisor_zero = (data2_i == '0);

`ifdef DIVIDER_SIGNED_EN
  logic neg_quot_q;
  logic neg_rem_q;

  assign dividend_ld = data1_i[DATA_WIDTH_1-1] ? (~data1_i + 1'b1) : data1_i;
  assign divisor_ld  = data2_i[DATA_WIDTH_2-1] ? (~data2_i + 1'b1) : data2_i;
  assign zero_quot   = data1_i[DATA_WIDTH_1-1] ? DATA_WIDTH_1'(1) : '1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (accept) begin
      neg_quot_q <= data1_i[DATA_WIDTH_1-1] ^ data2_i[DATA_WIDTH_2-1];
      neg_rem_q  <= data1_i[DATA_WIDTH_1-1];
    end
  end
`else
  assign dividend_ld = data1_i;
  assign divisor_ld  = data2_i;
  assign zero_quot   = '1;
`endif

  divider_step #(
    .DATA_WIDTH_2(DATA_WIDTH_2)
  ) u_step (
    .part_rem(rem_q),
    .divisor (divisor_q),
    .next_bit(quot_q[DATA_WIDTH_1-1]),
    .next_rem(step_rem),
    .quot_bit(step_bit)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = divisor_zero ? DONE : BUSY;
      BUSY: begin
        if (cnt_q == '0) begin
`ifdef DIVIDER_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end
      end
      FIX:     state_d = DONE;
      DONE:    if (consume) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // quot_q holds the dividend on accept; quotient bits shift in as dividend bits shift out.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      valid_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q      <= CNT_W'(DATA_WIDTH_1 - 1);
            divisor_q  <= divisor_ld;
            div_zero_q <= divisor_zero;
            if (divisor_zero) begin
              quot_q <= zero_quot;
              rem_q  <= {1'b0, DATA_WIDTH_2'(data1_i)};
            end else begin
              quot_q <= dividend_ld;
              rem_q  <= '0;
            end
          end
        end
        BUSY: begin
          quot_q <= {quot_q[DATA_WIDTH_1-2:0], step_bit};
          rem_q  <= step_rem;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
`ifdef DIVIDER_SIGNED_EN
        FIX: begin
          quot_q <= neg_quot_q ? (~quot_q + 1'b1) : quot_q;
          rem_q  <= {1'b0, neg_rem_q ? (~rem_q[DATA_WIDTH_2-1:0] + 1'b1)
                                     : rem_q[DATA_WIDTH_2-1:0]};
        end
`endif
        DONE: begin
          valid_q <= ~consume;
          if (consume) div_zero_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign quot_o     = quot_q;
  assign rem_o      = rem_q[DATA_WIDTH_2-1:0];
  assign div_zero_o = div_zero_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed corners plus random operands
// against an arithmetic reference model (signed when DIVIDER_SIGNED_EN is defined).
module tb_divider_seq;

  localparam int W = 16;

  logic         clk_i;
  logic         rst_n_i;
  logic [W-1:0] data1_i;
  logic [W-1:0] data2_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] quot_o;
  logic [W-1:0] rem_o;
  logic         div_zero_o;
  logic         valid_o;
  logic         ready_i;

  int total = 0;
  int bad   = 0;

  divider_seq #(
    .DATA_WIDTH_1(W),
    .DATA_WIDTH_2(W)
  ) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .quot_o    (quot_o),
    .rem_o     (rem_o),
    .div_zero_o(div_zero_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division from the operand rules, plus expected latency.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output int lat);
`ifdef DIVIDER_SIGNED_EN
    int sa, sb, qi, ri;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == '0) begin
      q = (sa >= 0) ? 16'hFFFF : 16'h0001;
      r = a;
      dz = 1'b1;
      lat = 1;
    end else begin
      qi = sa / sb;
      ri = sa % sb;
      q = qi[W-1:0];
      r = ri[W-1:0];
      dz = 1'b0;
      lat = W + 2;
    end
`else
    if (b == '0) begin
      q = '1;
      r = a;
      dz = 1'b1;
      lat = 1;
    end else begin
      q = a / b;
      r = a % b;
      dz = 1'b0;
      lat = W + 1;
    end
`endif
  endtask

  // Issue one division from a negedge; hold result for `hold` cycles before accepting.
  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit early_ready, input int hold);
    logic [W-1:0] eq, er;
    logic edz;
    int elat, k;
    model(a, b, eq, er, edz, elat);
    k = 0;
    while (!ready_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    check({tag, "_ready_in"}, ready_o, 1);
    data1_i = a;
    data2_i = b;
    valid_i = 1'b1;
    ready_i = early_ready;
    @(negedge clk_i);
    valid_i = 1'b0;
    data1_i = W'($urandom);
    data2_i = W'($urandom);
    k = 0;
    while (!valid_o && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    check({tag, "_latency"}, k, elat);
    check({tag, "_valid"}, valid_o, 1);
    check({tag, "_quot"}, quot_o, eq);
    check({tag, "_rem"}, rem_o, er);
    check({tag, "_dz"}, div_zero_o, edz);
    if (!early_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_i);
        check({tag, "_hold_quot"}, quot_o, eq);
        check({tag, "_hold_valid"}, valid_o, 1);
      end
      ready_i = 1'b1;
    end
    @(negedge clk_i);
    ready_i = 1'b0;
    check({tag, "_valid_after"}, valid_o, 0);
    check({tag, "_ready_after"}, ready_o, 1);
    check({tag, "_dz_after"}, div_zero_o, 0);
  endtask

  logic [W-1:0] bq, br, ra, rb;
  logic bdz;
  int blat, k;

  initial begin
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data1_i = '0;
    data2_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_ready", ready_o, 1);
    check("reset_valid", valid_o, 0);
    check("reset_quot", quot_o, 0);
    check("reset_rem", rem_o, 0);
    check("reset_dz", div_zero_o, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    model(16'd100, 16'd7, bq, br, bdz, blat);
    check("model_100_7_q", {16'd0, bq}, 32'd14);
    check("model_100_7_r", {16'd0, br}, 32'd2);
    do_div("d100_7", 16'd100, 16'd7, 1'b0, 0);
    do_div("dffff_1", 16'hFFFF, 16'd1, 1'b1, 0);
    do_div("d5_9", 16'd5, 16'd9, 1'b0, 2);
    do_div("d1234_0", 16'd1234, 16'd0, 1'b0, 0);
    do_div("d0_0", 16'd0, 16'd0, 1'b1, 0);
    do_div("d0_5", 16'd0, 16'd5, 1'b0, 1);
`ifdef DIVIDER_SIGNED_EN
    do_div("s_m7_2", 16'hFFF9, 16'd2, 1'b0, 0);
    check("s_m7_2_q_const", quot_o, 16'hFFFD);
    do_div("s_min_m1", 16'h8000, 16'hFFFF, 1'b0, 0);
    do_div("s_m9_0", 16'hFFF7, 16'd0, 1'b1, 0);
`endif

    // Backpressure: result and flags must hold while ready_i is low and new operands wait.
    model(16'd200, 16'd3, bq, br, bdz, blat);
    data1_i = 16'd200;
    data2_i = 16'd3;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    k = 0;
    while (!valid_o && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    check("bp_latency", k, blat);
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'b1;
      data1_i = W'($urandom);
      data2_i = W'($urandom);
      @(negedge clk_i);
      check("bp_valid", valid_o, 1);
      check("bp_quot", quot_o, bq);
      check("bp_rem", rem_o, br);
      check("bp_ready", ready_o, 0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check("bp_release_ready", ready_o, 1);
    check("bp_release_valid", valid_o, 0);

    // Reset in the middle of an iteration.
    data1_i = 16'd4321;
    data2_i = 16'd17;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("mid_busy_ready", ready_o, 0);
    rst_n_i = 1'b0;
    #1;
    check("mid_rst_ready", ready_o, 1);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_quot", quot_o, 0);
    check("mid_rst_rem", rem_o, 0);
    check("mid_rst_dz", div_zero_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    do_div("post_rst", 16'd1000, 16'd10, 1'b0, 0);

    // Random operands with a bias toward corner divisors/dividends.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 16'd1;
        2:       rb = 16'hFFFF;
        3:       rb = 16'h8000;
        4:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       ra = 16'h8000;
        1:       ra = 16'hFFFF;
        2:       ra = '0;
        default: ra = W'($urandom);
      endcase
      do_div("rnd", ra, rb, bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
